iter16_divider: RTL and testbench
=================================

# iter16_divider

Iterative 32-bit unsigned divider that sits beside the 16-iteration multiplier in the processor's execute stage and shares its handshake: `in_valid` starts an operation, `stall` freezes the pipeline, `out_valid` marks the result cycle. It retires two quotient bits per cycle by restoring division, giving 16 compute cycles. The result is packed `{remainder, quotient}` so the processor writes HI/LO exactly as it does for the multiplier's 64-bit product.

## Interface
- No parameters. Widths are fixed by package constants.
- `clk` input 1: clock.
- `rst_n` input 1: synchronous, active-low reset.
- `in_valid` input 1: start request. Sampled only in IDLE.
- `dividend` input 32: unsigned dividend. Captured when `in_valid` is sampled in IDLE.
- `divisor` input 32: unsigned divisor. Captured with `dividend`.
- `result` output 64: `{remainder[31:0], quotient[31:0]}`, registered.
- `out_valid` output 1: high for exactly one cycle (END).
- `stall` output 1: high while the processor must hold.

## Operation
- FSM states: IDLE=0, OP=1, END=2. Encoding value 3 is illegal and goes to IDLE.
- **IDLE transitions:**
  - `in_valid`=1: capture operands and go to OP.
  - `in_valid`=0: stay in IDLE.
- **Registers loaded on capture:**
  - `quo_r` ← dividend
  - `rem_r[32:0]` ← 0
  - `dvs_r` ← divisor
  - `cnt_r` ← 0
- **OP, one cycle:** apply two chained restoring steps. Each step does the following:
  - `rem = {rem[31:0], quo[31]}` and `quo = quo << 1`.
  - If `rem >= {1'b0, dvs_r}`, then `rem -= dvs_r` and `quo[0] = 1`.
- **OP counter:** `cnt_r` increments by 1 each cycle. When `cnt_r` reaches 15, go to END.
- **END:** go to IDLE unconditionally. `in_valid` is ignored in END and in OP; the requester re-asserts it in IDLE.
- **`result` register:**
  - Loaded with `{rem_r[31:0], quo_r}` on the transition from OP to END.
  - Holds that value through END and IDLE until the next operation's END.
- **Divide by zero:** no exception. Returns quotient 0xFFFFFFFF and remainder = dividend, which the restoring algorithm produces naturally.
- **Other boundary cases:**
  - Divisor > dividend: quotient 0, remainder = dividend.
  - Divisor 1: quotient = dividend, remainder 0.
- **Reset** (including mid-OP), effective next edge:
  - State IDLE.
  - All registers 0, including `result`.
  - `out_valid`=0 and `stall`=0.

## Timing
- Reset values: `result`=0, `out_valid`=0, `stall`=0.
- **`stall`:** combinational, `stall = (IDLE && in_valid) || OP`.
- **`out_valid`:** combinational, `out_valid = (state == END)`.
- **Normal latency:**
  - `in_valid` sampled in IDLE at cycle 0.
  - OP occupies cycles 1–16.
  - END at cycle 17: `out_valid`=1, `stall`=0, `result` valid.
  - `stall` is high in cycles 0–16.
- **Throughput:** the earliest next accept is cycle 18, in IDLE.
- **Critical path:** two 33-bit subtract/compare stages in series.

## Configuration
- Macro: `DIV_ZERO_FASTPATH_EN`.
- **Defined:**
  - In IDLE with `in_valid`=1 and `divisor`=0, go directly to END.
  - `result` ← `{dividend, 32'hFFFFFFFF}`.
  - `out_valid` at cycle 1; `stall` high in cycle 0 only.
  - Nonzero divisors are unaffected.
- **Undefined:** a zero divisor runs the full 16 OP cycles and produces the identical `result` value at cycle 17.
- Result values never differ between builds; only latency does.

## Structure
- **Package `div_pkg`:**
  - State encoding constants: `S_IDLE`, `S_OP`, `S_END`.
  - `DIV_W`=32.
  - `DIV_ITER`=16.
  - `DIV_BITS_PER_CYC`=2.
- **Sub-module `div_step`:**
  - Purely combinational, one restoring step.
  - Inputs: `rem_in[32:0]`, `quo_in[31:0]`, `dvs[31:0]`.
  - Outputs: `rem_out`, `quo_out`.
  - Instantiated twice in series inside `iter16_divider`.

## Test plan
- **Basic division:** dividend 100, divisor 7, `in_valid` pulse in IDLE → `out_valid` exactly at cycle 17, `result` = `{32'd2, 32'd14}`, `stall` high cycles 0–16.
- **Full-range dividend:** dividend 0xFFFFFFFF, divisor 1 → quotient 0xFFFFFFFF, remainder 0. Then dividend 0xFFFFFFFF, divisor 0x10000 → quotient 0xFFFF, remainder 0xFFFF.
- **Small dividend:** dividend 5, divisor 10 → quotient 0, remainder 5. `result` then holds stable for 10 idle cycles with `out_valid`=0.
- **Divide by zero:** dividend 0x1234, divisor 0 → quotient 0xFFFFFFFF, remainder 0x1234.
  - Without `DIV_ZERO_FASTPATH_EN`: `out_valid` at cycle 17.
  - With it: `out_valid` at cycle 1.
- **`in_valid` held high:** hold `in_valid` high continuously with operands 100/7 then 81/9 → second operation accepted only in IDLE at cycle 18. Its result `{0, 9}` appears at cycle 35.
- **Reset mid-operation:** assert `rst_n` low at cycle 8 of an operation → next cycle IDLE, `result`=0, `stall`=0, `out_valid`=0. A following 100/7 operation completes correctly.

Source files
------------

// File: rtl/iter16_divider_pkg.sv
// div_pkg: shared constants for the iterative 32-bit unsigned divider.
//   DIV_W            operand width
//   DIV_ITER         compute cycles per operation
//   DIV_BITS_PER_CYC quotient bits retired per compute cycle
//   S_IDLE/S_OP/S_END FSM encodings (2'd3 is illegal and recovers to IDLE)
package div_pkg;

  localparam int DIV_W            = 32;
  localparam int DIV_ITER         = 16;
  localparam int DIV_BITS_PER_CYC = 2;
  localparam int CNT_W            = $clog2(DIV_ITER);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_OP   = 2'd1;
  localparam logic [1:0] S_END  = 2'd2;

endpackage

// File: rtl/iter16_divider_step.sv
// div_step: one combinational restoring-division step.
//   rem_in  [32:0] partial remainder in
//   quo_in  [31:0] shifting dividend/quotient in
//   dvs     [31:0] divisor
//   rem_out [32:0] partial remainder out
//   quo_out [31:0] dividend/quotient out, new quotient bit in [0]
module div_step
  import div_pkg::*;
(
  input  logic [DIV_W:0]   rem_in,
  input  logic [DIV_W-1:0] quo_in,
  input  logic [DIV_W-1:0] dvs,
  output logic [DIV_W:0]   rem_out,
  output logic [DIV_W-1:0] quo_out
);

  logic [DIV_W:0] sh;
  logic [DIV_W:0] dif;
  logic           ge;

  // Remainder stays below the divisor between steps, so the shifted value
  // always fits in 33 bits and the subtract never underflows when taken.
  assign sh      = {rem_in[DIV_W-1:0], quo_in[DIV_W-1]};
  assign ge      = (sh >= {1'b0, dvs});
  assign dif     = sh - {1'b0, dvs};
  assign rem_out = ge ? dif : sh;
  assign quo_out = {quo_in[DIV_W-2:0], ge};

endmodule

// File: rtl/iter16_divider.sv
// iter16_divider: iterative 32-bit unsigned restoring divider, two quotient
// bits per cycle, 16 compute cycles. Shares the multiplier's handshake.
//   clk, rst_n  clock, synchronous active-low reset
//   in_valid    start request, sampled only in IDLE
//   dividend    unsigned dividend, captured with in_valid in IDLE
//   divisor     unsigned divisor, captured with dividend
//   result      registered {remainder, quotient}
//   out_valid   high for the single END cycle
//   stall       high while the processor must hold
// Optional build macro DIV_ZERO_FASTPATH_EN: a zero divisor skips the compute
// cycles and goes straight to END with the same result value.
module iter16_divider
  import div_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  input  logic [DIV_W-1:0]     dividend,
  input  logic [DIV_W-1:0]     divisor,
  output logic [2*DIV_W-1:0]   result,
  output logic                 out_valid,
  output logic                 stall
);

  logic [1:0]         state_r, state_nx;
  logic [DIV_W-1:0]   quo_r;
  logic [DIV_W:0]     rem_r;
  logic [DIV_W-1:0]   dvs_r;
  logic [CNT_W-1:0]   cnt_r;
  logic [2*DIV_W-1:0] result_r;

  logic accept;
  logic last_op;

  // Chain of restoring steps evaluated in one cycle; entry 0 is the register
  // state, the final entry is next cycle's state.
  logic [DIV_BITS_PER_CYC:0][DIV_W:0]   rem_ch;
  logic [DIV_BITS_PER_CYC:0][DIV_W-1:0] quo_ch;

  assign rem_ch[0] = rem_r;
  assign quo_ch[0] = quo_r;

  genvar g;
  generate
    for (g = 0; g < DIV_BITS_PER_CYC; g++) begin : g_step
      div_step u_step (
        .rem_in  (rem_ch[g]),
        .quo_in  (quo_ch[g]),
        .dvs     (dvs_r),
        .rem_out (rem_ch[g+1]),
        .quo_out (quo_ch[g+1])
      );
    end
  endgenerate

  assign accept  = (state_r == S_IDLE) && in_valid;
  assign last_op = (state_r == S_OP) && (cnt_r == CNT_W'(DIV_ITER-1));

  always_comb begin
    state_nx = state_r;
    case (state_r)
      S_IDLE: begin
        if (in_valid) begin
          state_nx = S_OP;
`ifdef DIV_ZERO_FASTPATH_EN
          if (divisor == '0) state_nx = S_END;
`endif
        end
      end
      S_OP:    if (last_op) state_nx = S_END;
      S_END:   state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r  <= S_IDLE;
      quo_r    <= '0;
      rem_r    <= '0;
      dvs_r    <= '0;
      cnt_r    <= '0;
      result_r <= '0;
    end else begin
      state_r <= state_nx;
      if (accept) begin
        quo_r <= dividend;
        rem_r <= '0;
        dvs_r <= divisor;
        cnt_r <= '0;
`ifdef DIV_ZERO_FASTPATH_EN
        // Same value the full iteration would produce for a zero divisor.
        if (divisor == '0) result_r <= {dividend, {DIV_W{1'b1}}};
`endif
      end else if (state_r == S_OP) begin
        rem_r <= rem_ch[DIV_BITS_PER_CYC];
        quo_r <= quo_ch[DIV_BITS_PER_CYC];
        cnt_r <= cnt_r + 1'b1;
        // Capture the post-step values so END already shows the final answer.
        if (last_op)
          result_r <= {rem_ch[DIV_BITS_PER_CYC][DIV_W-1:0], quo_ch[DIV_BITS_PER_CYC]};
      end
    end
  end

  assign result    = result_r;
  assign out_valid = (state_r == S_END);
  assign stall     = accept || (state_r == S_OP);

endmodule

// File: tb/tb_iter16_divider.sv
// Scoreboard bench for iter16_divider: stimulus pushes expected {rem,quo}
// with the cycle it must appear; a monitor pops on out_valid.
module tb_iter16_divider;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic [63:0] result;
  logic        out_valid;
  logic        stall;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    logic [63:0] res;
    int          due;
  } exp_t;
  exp_t sb[$];

`ifdef DIV_ZERO_FASTPATH_EN
  localparam int ZLAT = 1;
`else
  localparam int ZLAT = 17;
`endif

  iter16_divider dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .dividend  (dividend),
    .divisor   (divisor),
    .result    (result),
    .out_valid (out_valid),
    .stall     (stall)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
    end
  endtask

  // Monitor: every out_valid must match the oldest pending expectation,
  // both in value and in cycle; an expectation past due is reported missing.
  always @(negedge clk) begin
    if (out_valid) begin
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_out_valid cyc=%0d got=%h want=none", cyc, result);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("result", result, e.res);
        chk("out_cycle", 64'(cyc), 64'(e.due));
      end
    end else if (sb.size() > 0 && cyc > sb[0].due) begin
      exp_t e;
      e = sb.pop_front();
      checks++; errors++;
      $display("FAIL missing_out_valid cyc=%0d got=none want=%h@%0d", cyc, e.res, e.due);
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // One pulsed operation: stall must be high for cycles 0..lat-1 and low at END.
  task automatic run_op(input logic [31:0] dd, input logic [31:0] dv,
                        input logic [63:0] exp, input int lat);
    exp_t e;
    in_valid = 1'b1; dividend = dd; divisor = dv;
    e.res = exp; e.due = cyc + lat;
    sb.push_back(e);
    for (int i = 0; i < lat; i++) begin
      @(negedge clk); chk("stall_busy", 64'(stall), 64'd1);
      tick();
      in_valid = 1'b0;
    end
    @(negedge clk); chk("stall_end", 64'(stall), 64'd0);
    tick();
  endtask

  initial begin
    int st;
    exp_t e;
    rst_n = 1'b0; in_valid = 1'b0; dividend = '0; divisor = '0;
    repeat (3) tick();
    @(negedge clk);
    chk("rst_result", result, 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_stall", 64'(stall), 64'd0);
    tick();
    rst_n = 1'b1;
    tick();

    run_op(32'd100, 32'd7, {32'd2, 32'd14}, 17);
    run_op(32'hFFFFFFFF, 32'd1, {32'd0, 32'hFFFFFFFF}, 17);
    run_op(32'hFFFFFFFF, 32'h10000, {32'h0000FFFF, 32'h0000FFFF}, 17);
    run_op(32'd5, 32'd10, {32'd5, 32'd0}, 17);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("hold_result", result, {32'd5, 32'd0});
      chk("hold_out_valid", 64'(out_valid), 64'd0);
      tick();
    end
    run_op(32'h1234, 32'd0, {32'h1234, 32'hFFFFFFFF}, ZLAT);
    run_op(32'd7, 32'd7, {32'd0, 32'd1}, 17);

    // in_valid held high across two operations; operands change during OP.
    st = cyc;
    in_valid = 1'b1; dividend = 32'd100; divisor = 32'd7;
    e.res = {32'd2, 32'd14}; e.due = st + 17; sb.push_back(e);
    e.res = {32'd0, 32'd9};  e.due = st + 35; sb.push_back(e);
    tick();
    dividend = 32'd81; divisor = 32'd9;
    while (cyc < st + 17) tick();
    @(negedge clk); chk("held_stall_end", 64'(stall), 64'd0);
    tick();
    @(negedge clk); chk("held_stall_accept", 64'(stall), 64'd1);
    tick();
    in_valid = 1'b0;
    while (cyc < st + 36) tick();

    // Reset asserted at cycle 8 of an operation.
    st = cyc;
    in_valid = 1'b1; dividend = 32'd100; divisor = 32'd7;
    tick();
    in_valid = 1'b0;
    while (cyc < st + 8) tick();
    rst_n = 1'b0;
    tick();
    @(negedge clk);
    chk("midrst_result", result, 64'd0);
    chk("midrst_stall", 64'(stall), 64'd0);
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    tick();
    rst_n = 1'b1;
    tick();
    run_op(32'd100, 32'd7, {32'd2, 32'd14}, 17);

    repeat (3) tick();
    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout cyc=%0d got=running want=finished", cyc);
    $fatal(1, "timeout");
  end

endmodule
